// File: rtl/instruction_memory.sv
`default_nettype none
// ============================================================================
// Module   : instruction_memory
// Purpose  : Fetch-stage instruction memory. The debug unit loads the program
//            as a big-endian byte stream. A three-state FSM (IDLE/LOAD/DONE)
//            assembles the bytes into NBITS-bit words and writes them from
//            word 0 upward. The read path is combinational and indexed by the
//            program counter.
// Ports    : i_clk, i_rst (async, active-high)
//            i_load_en       - load session enable (level)
//            i_byte_valid    - i_byte carries a program byte this cycle
//            i_byte          - program byte, MSB of each word first
//            i_pc            - byte address from the program counter
//            o_instr         - addressed word (0 when the PC is out of range)
//            o_misaligned    - i_pc[1:0] != 0 (flag only)
//            o_out_of_range  - i_pc >= 4*CELLS
//            o_loading       - FSM is in LOAD
//            o_load_done     - FSM is in DONE (program ready)
//            o_full          - last session ended by filling every cell
//            o_word_count    - words written in the current/last session
// Revision : 1.0 - initial release
// ============================================================================
module instruction_memory #(
    parameter int               NBITS     = 32,
    parameter int               CELLS     = 64,
    parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  wire logic                      i_clk,
    input  wire logic                      i_rst,
    input  wire logic                      i_load_en,
    input  wire logic                      i_byte_valid,
    input  wire logic [7:0]                i_byte,
    input  wire logic [NBITS-1:0]          i_pc,
    output logic      [NBITS-1:0]          o_instr,
    output logic                           o_misaligned,
    output logic                           o_out_of_range,
    output logic                           o_loading,
    output logic                           o_load_done,
    output logic                           o_full,
    output logic      [$clog2(CELLS):0]    o_word_count
);

    localparam int c_AW = $clog2(CELLS);

    // First byte address past the end of memory.
    localparam logic [NBITS-1:0] c_BYTE_LIMIT = NBITS'(4 * CELLS);

    // Write pointer value when the word being written lands in the last cell.
    localparam logic [c_AW:0] c_LAST_PTR = (c_AW + 1)'(CELLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t             state_q,    state_d;
    logic [23:0]        asm_q,      asm_d;       // first three bytes of a word
    logic [1:0]         byte_idx_q, byte_idx_d;
    // One bit wider than the cell index so it can count up to CELLS; it also
    // serves as the word count for the session.
    logic [c_AW:0]      wr_ptr_q,   wr_ptr_d;
    logic               full_q,     full_d;

    logic [NBITS-1:0]   mem_q [CELLS];

    // Write port, decided by the FSM
    logic               wr_en;
    logic [NBITS-1:0]   wr_word;
    logic [c_AW-1:0]    wr_addr;

    // ------------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        asm_d      = asm_q;
        byte_idx_d = byte_idx_q;
        wr_ptr_d   = wr_ptr_q;
        full_d     = full_q;
        wr_en      = 1'b0;
        wr_word    = NBITS'({asm_q, i_byte});
        wr_addr    = wr_ptr_q[c_AW-1:0];

        case (state_q)
            ST_IDLE: begin
                // Word count and full flag survive in IDLE so the debug unit
                // can inspect the outcome of the previous session; they are
                // cleared only when a new session starts.
                if (i_load_en) begin
                    state_d    = ST_LOAD;
                    asm_d      = '0;
                    byte_idx_d = '0;
                    wr_ptr_d   = '0;
                    full_d     = 1'b0;
                end
            end

            ST_LOAD: begin
                if (!i_load_en) begin
                    // Abort beats a byte arriving on the same edge. A partial
                    // word is dropped; completed words stay in memory.
                    state_d    = ST_IDLE;
                    asm_d      = '0;
                    byte_idx_d = '0;
                end else if (i_byte_valid) begin
                    if (byte_idx_q == 2'd3) begin
                        wr_en      = 1'b1;
                        wr_ptr_d   = wr_ptr_q + 1'b1;
                        asm_d      = '0;
                        byte_idx_d = '0;
                        // Filling the last cell ends the session as full even
                        // when that word is the halt marker.
                        if (wr_ptr_q == c_LAST_PTR) begin
                            state_d = ST_DONE;
                            full_d  = 1'b1;
                        end else if (wr_word == HALT_WORD) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        asm_d      = {asm_q[15:0], i_byte};
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end

            ST_DONE: begin
                // Bytes are ignored; dropping the enable re-arms the block so
                // the next session needs a fresh 0->1 on i_load_en.
                if (!i_load_en) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            asm_q      <= '0;
            byte_idx_q <= '0;
            wr_ptr_q   <= '0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            asm_q      <= asm_d;
            byte_idx_q <= byte_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            full_q     <= full_d;
        end
    end

    // ------------------------------------------------------------------------
    // Storage: cleared by reset so a stale program can never be fetched
    // after a reset, even one that interrupts a load.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < CELLS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_word;
        end
    end

    // ------------------------------------------------------------------------
    // Read path (combinational). The low two PC bits are flagged but do not
    // affect which word is returned; out-of-range fetches return a NOP (0).
    // ------------------------------------------------------------------------
    logic [c_AW-1:0] rd_addr;

    always_comb begin
        rd_addr        = i_pc[2 +: c_AW];
        o_misaligned   = (i_pc[1:0] != 2'b00);
        o_out_of_range = (i_pc >= c_BYTE_LIMIT);
        o_instr        = o_out_of_range ? '0 : mem_q[rd_addr];
    end

    // ------------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------------
    assign o_loading    = (state_q == ST_LOAD);
    assign o_load_done  = (state_q == ST_DONE);
    assign o_full       = full_q;
    assign o_word_count = wr_ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_memory
// Purpose  : Self-checking bench for instruction_memory. Stimulus pushes the
//            expected read/status values into a queue; a monitor pops and
//            compares them on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_memory;

    logic        i_clk;
    logic        i_rst;
    logic        i_load_en;
    logic        i_byte_valid;
    logic [7:0]  i_byte;
    logic [31:0] i_pc;
    logic [31:0] o_instr;
    logic        o_misaligned;
    logic        o_out_of_range;
    logic        o_loading;
    logic        o_load_done;
    logic        o_full;
    logic [6:0]  o_word_count;

    instruction_memory #(
        .NBITS     (32),
        .CELLS     (64),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_load_en      (i_load_en),
        .i_byte_valid   (i_byte_valid),
        .i_byte         (i_byte),
        .i_pc           (i_pc),
        .o_instr        (o_instr),
        .o_misaligned   (o_misaligned),
        .o_out_of_range (o_out_of_range),
        .o_loading      (o_loading),
        .o_load_done    (o_load_done),
        .o_full         (o_full),
        .o_word_count   (o_word_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          is_read;
        string       tag;
        logic [31:0] instr;
        bit          mis;
        bit          oor;
        bit          loading;
        bit          done;
        bit          full;
        int          count;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    task automatic cmp(input string tag, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%h expected=%h", tag, field, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge i_clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                if (e.is_read) begin
                    cmp(e.tag, "instr", o_instr, e.instr);
                    cmp(e.tag, "misaligned", 32'(o_misaligned), 32'(e.mis));
                    cmp(e.tag, "out_of_range", 32'(o_out_of_range), 32'(e.oor));
                end else begin
                    cmp(e.tag, "loading", 32'(o_loading), 32'(e.loading));
                    cmp(e.tag, "load_done", 32'(o_load_done), 32'(e.done));
                    cmp(e.tag, "full", 32'(o_full), 32'(e.full));
                    cmp(e.tag, "word_count", 32'(o_word_count), 32'(e.count));
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (each starts and ends 1 ns after a rising edge)
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic exp_read(input string tag, input logic [31:0] pc,
                            input logic [31:0] instr, input bit mis, input bit oor);
        exp_t e;
        e = '{is_read: 1'b1, tag: tag, instr: instr, mis: mis, oor: oor,
              loading: 1'b0, done: 1'b0, full: 1'b0, count: 0};
        i_pc = pc;
        sb.push_back(e);
        @(negedge i_clk);
        tick();
    endtask

    task automatic exp_status(input string tag, input bit loading, input bit done,
                              input bit full, input int count);
        exp_t e;
        e = '{is_read: 1'b0, tag: tag, instr: 32'h0, mis: 1'b0, oor: 1'b0,
              loading: loading, done: done, full: full, count: count};
        sb.push_back(e);
        @(negedge i_clk);
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        i_byte_valid = 1'b0;
        repeat (gap) tick();
        i_byte_valid = 1'b1;
        i_byte       = b;
        tick();
        i_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8],  gap);
        send_byte(w[7:0],   gap);
    endtask

    task automatic new_session();
        i_load_en = 1'b0;
        tick();
        i_load_en = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        i_rst        = 1'b1;
        i_load_en    = 1'b0;
        i_byte_valid = 1'b0;
        i_byte       = 8'h00;
        i_pc         = 32'h0;
        #35;
        i_rst = 1'b0;
        tick();

        // Reset state
        exp_status("reset_status", 0, 0, 0, 0);
        exp_read("reset_pc0", 32'd0, 32'h0, 0, 0);
        exp_read("reset_pc4", 32'd4, 32'h0, 0, 0);
        exp_read("reset_pc8", 32'd8, 32'h0, 0, 0);

        // Basic load
        i_load_en = 1'b1;
        tick();
        exp_status("basic_loading", 1, 0, 0, 0);
        send_word(32'h2008_0005, 0);
        send_word(32'h2009_0007, 0);
        send_word(32'hFFFF_FFFF, 0);
        exp_status("basic_done", 0, 1, 0, 3);
        exp_read("basic_pc0", 32'd0,  32'h2008_0005, 0, 0);
        exp_read("basic_pc4", 32'd4,  32'h2009_0007, 0, 0);
        exp_read("basic_pc8", 32'd8,  32'hFFFF_FFFF, 0, 0);
        exp_read("basic_pc12", 32'd12, 32'h0, 0, 0);
        i_load_en = 1'b0;
        tick();
        exp_status("basic_idle", 0, 0, 0, 3);

        // Gapped bytes, with done checked just before the final byte
        i_load_en = 1'b1;
        tick();
        send_word(32'h2008_0005, 1);
        send_word(32'h2009_0007, 2);
        send_byte(8'hFF, 3);
        send_byte(8'hFF, 1);
        send_byte(8'hFF, 2);
        exp_status("gap_pre_last", 1, 0, 0, 2);
        send_byte(8'hFF, 3);
        exp_status("gap_done", 0, 1, 0, 3);
        exp_read("gap_pc0", 32'd0, 32'h2008_0005, 0, 0);
        exp_read("gap_pc4", 32'd4, 32'h2009_0007, 0, 0);
        exp_read("gap_pc8", 32'd8, 32'hFFFF_FFFF, 0, 0);

        // Full: 64 non-halt words, word n = n
        new_session();
        for (int n = 0; n < 64; n++) send_word(32'(n), 0);
        exp_status("full_status", 0, 1, 1, 64);
        exp_read("full_pc252", 32'd252, 32'd63, 0, 0);
        exp_read("full_pc0",   32'd0,   32'd0,  0, 0);
        exp_read("full_pc8",   32'd8,   32'd2,  0, 0);

        // Abort after 2 words + 2 bytes; a third byte races the abort
        new_session();
        send_word(32'hA000_0001, 0);
        send_word(32'hA000_0002, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        i_byte_valid = 1'b1;
        i_byte       = 8'h33;
        i_load_en    = 1'b0;
        tick();
        i_byte_valid = 1'b0;
        exp_status("abort_status", 0, 0, 0, 2);
        exp_read("abort_pc0",  32'd0,  32'hA000_0001, 0, 0);
        exp_read("abort_pc4",  32'd4,  32'hA000_0002, 0, 0);
        exp_read("abort_pc8",  32'd8,  32'd2, 0, 0);
        exp_read("abort_pc12", 32'd12, 32'd3, 0, 0);

        // Reload from word 0
        i_load_en = 1'b1;
        tick();
        send_word(32'hB000_0000, 0);
        send_word(32'hFFFF_FFFF, 0);
        exp_status("reload_status", 0, 1, 0, 2);
        exp_read("reload_pc0", 32'd0, 32'hB000_0000, 0, 0);
        exp_read("reload_pc4", 32'd4, 32'hFFFF_FFFF, 0, 0);
        exp_read("reload_pc8", 32'd8, 32'd2, 0, 0);

        // Address checks
        exp_read("addr_misaligned", 32'd2,   32'hB000_0000, 1, 0);
        exp_read("addr_oor256",     32'd256, 32'h0, 0, 1);
        exp_read("addr_pc255",      32'd255, 32'd63, 1, 0);
        exp_read("addr_oor_top",    32'hFFFF_FFFC, 32'h0, 0, 1);

        // Halt marker landing in the last cell
        new_session();
        for (int n = 0; n < 63; n++) send_word(32'h100 + 32'(n), 0);
        send_word(32'hFFFF_FFFF, 0);
        exp_status("halt_last_status", 0, 1, 1, 64);
        exp_read("halt_last_pc252", 32'd252, 32'hFFFF_FFFF, 0, 0);
        exp_read("halt_last_pc248", 32'd248, 32'h13E, 0, 0);

        // Reset in the middle of a word
        new_session();
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        i_rst = 1'b1;
        #2;
        exp_status("rst_mid_status", 0, 0, 0, 0);
        exp_read("rst_mid_pc0",   32'd0,   32'h0, 0, 0);
        exp_read("rst_mid_pc252", 32'd252, 32'h0, 0, 0);
        i_load_en = 1'b0;
        tick();
        i_rst = 1'b0;
        tick();
        exp_status("post_rst_status", 0, 0, 0, 0);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d pending expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
